// File: rtl/conv_window_feeder.sv
// Builds 3x3 windows from a raster pixel stream and runs one handshake per window with the dot-product engine.
// Optional RELU_EN macro: clamp negative engine results to zero before they reach res_data.
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int RW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [DW-1:0] coef_data,
    input  logic          sof,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic          initate,
    output logic [DW-1:0] img_bit_0,
    output logic [DW-1:0] img_bit_1,
    output logic [DW-1:0] img_bit_2,
    output logic [DW-1:0] img_bit_3,
    output logic [DW-1:0] img_bit_4,
    output logic [DW-1:0] img_bit_5,
    output logic [DW-1:0] img_bit_6,
    output logic [DW-1:0] img_bit_7,
    output logic [DW-1:0] img_bit_8,
    output logic [DW-1:0] filter_0,
    output logic [DW-1:0] filter_1,
    output logic [DW-1:0] filter_2,
    output logic [DW-1:0] filter_3,
    output logic [DW-1:0] filter_4,
    output logic [DW-1:0] filter_5,
    output logic [DW-1:0] filter_6,
    output logic [DW-1:0] filter_7,
    output logic [DW-1:0] filter_8,
    input  logic [RW-1:0] Result_out,
    input  logic          ready_dot,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    input  logic          res_ready
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RBW = $clog2(IMG_H);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [RBW-1:0]  row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   res_q, res_d;

    logic [DW-1:0]   lb0_mem [IMG_W];
    logic [DW-1:0]   lb1_mem [IMG_W];

    logic            pix_acc;
    logic            win_done;
    logic            coef_wr;
    logic [RBW-1:0]  eff_row;
    logic [CW-1:0]   eff_col;
    logic [DW-1:0]   col_in [3];

    assign pix_ready = rst_n && (state_q == S_FILL);
    assign initate   = rst_n && (state_q == S_ISSUE);
    assign res_valid = rst_n && (state_q == S_EMIT);
    assign res_data  = res_q;

    assign pix_acc  = pix_valid && pix_ready;
    // sof re-anchors the accepted pixel at (0,0) before any position-dependent decision
    assign eff_row  = sof ? '0 : row_q;
    assign eff_col  = sof ? '0 : col_q;
    assign win_done = pix_acc && (eff_row >= RBW'(2)) && (eff_col >= CW'(2));
    assign coef_wr  = coef_we && (state_q == S_FILL);

    // lb0 holds row r-2, lb1 holds row r-1; both are read at the incoming column
    assign col_in[0] = lb0_mem[eff_col];
    assign col_in[1] = lb1_mem[eff_col];
    assign col_in[2] = pix_data;

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb0_mem[eff_col] <= lb1_mem[eff_col];
            lb1_mem[eff_col] <= pix_data;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (pix_acc) begin
            if (eff_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (eff_row == RBW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            S_FILL:  if (win_done) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ready_dot) begin
                    state_d = S_EMIT;
`ifdef RELU_EN
                    res_d = Result_out[RW-1] ? '0 : Result_out;
`else
                    res_d = Result_out;
`endif
                end
            end
            S_EMIT:  if (res_ready) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            row_q   <= '0;
            col_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            res_q   <= res_d;
        end
    end

    // Each window row is a 3-tap shift register; the newest column enters on the right
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        logic [DW-1:0] tap_q [3];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tap_q[0] <= '0;
                tap_q[1] <= '0;
                tap_q[2] <= '0;
            end else if (pix_acc) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
                tap_q[2] <= col_in[gi];
            end
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_coef
        logic [DW-1:0] coef_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                coef_q <= '0;
            end else if (coef_wr && (coef_addr == 4'(gi))) begin
                coef_q <= coef_data;
            end
        end
    end

    assign img_bit_0 = g_win_row[0].tap_q[0];
    assign img_bit_1 = g_win_row[0].tap_q[1];
    assign img_bit_2 = g_win_row[0].tap_q[2];
    assign img_bit_3 = g_win_row[1].tap_q[0];
    assign img_bit_4 = g_win_row[1].tap_q[1];
    assign img_bit_5 = g_win_row[1].tap_q[2];
    assign img_bit_6 = g_win_row[2].tap_q[0];
    assign img_bit_7 = g_win_row[2].tap_q[1];
    assign img_bit_8 = g_win_row[2].tap_q[2];

    assign filter_0 = g_coef[0].coef_q;
    assign filter_1 = g_coef[1].coef_q;
    assign filter_2 = g_coef[2].coef_q;
    assign filter_3 = g_coef[3].coef_q;
    assign filter_4 = g_coef[4].coef_q;
    assign filter_5 = g_coef[5].coef_q;
    assign filter_6 = g_coef[6].coef_q;
    assign filter_7 = g_coef[7].coef_q;
    assign filter_8 = g_coef[8].coef_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 frame; the bench plays the dot-product engine.
// Expected results follow RELU_EN when the macro is defined for the build.
module tb_conv_window_feeder;
    localparam int DW = 8;
    localparam int RW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_addr = '0;
    logic [DW-1:0] coef_data = '0;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          initate;
    logic [DW-1:0] img_bit_0, img_bit_1, img_bit_2, img_bit_3, img_bit_4;
    logic [DW-1:0] img_bit_5, img_bit_6, img_bit_7, img_bit_8;
    logic [DW-1:0] filter_0, filter_1, filter_2, filter_3, filter_4;
    logic [DW-1:0] filter_5, filter_6, filter_7, filter_8;
    logic [RW-1:0] Result_out = '0;
    logic          ready_dot = 1'b0;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int res_list[$];
    int win_at[$];
    logic [DW-1:0] first_taps [9];
    logic [DW-1:0] tap_w [9];
    logic [DW-1:0] fil_w [9];

    always #5 clk = ~clk;

    conv_window_feeder #(.IMG_W(4), .IMG_H(4), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .initate(initate),
        .img_bit_0(img_bit_0), .img_bit_1(img_bit_1), .img_bit_2(img_bit_2),
        .img_bit_3(img_bit_3), .img_bit_4(img_bit_4), .img_bit_5(img_bit_5),
        .img_bit_6(img_bit_6), .img_bit_7(img_bit_7), .img_bit_8(img_bit_8),
        .filter_0(filter_0), .filter_1(filter_1), .filter_2(filter_2),
        .filter_3(filter_3), .filter_4(filter_4), .filter_5(filter_5),
        .filter_6(filter_6), .filter_7(filter_7), .filter_8(filter_8),
        .Result_out(Result_out), .ready_dot(ready_dot),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    assign tap_w[0] = img_bit_0;
    assign tap_w[1] = img_bit_1;
    assign tap_w[2] = img_bit_2;
    assign tap_w[3] = img_bit_3;
    assign tap_w[4] = img_bit_4;
    assign tap_w[5] = img_bit_5;
    assign tap_w[6] = img_bit_6;
    assign tap_w[7] = img_bit_7;
    assign tap_w[8] = img_bit_8;
    assign fil_w[0] = filter_0;
    assign fil_w[1] = filter_1;
    assign fil_w[2] = filter_2;
    assign fil_w[3] = filter_3;
    assign fil_w[4] = filter_4;
    assign fil_w[5] = filter_5;
    assign fil_w[6] = filter_6;
    assign fil_w[7] = filter_7;
    assign fil_w[8] = filter_8;

    task automatic load_coefs(input logic [9*DW-1:0] cv);
        for (int k = 0; k < 9; k++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(k);
            coef_data = cv[DW*k +: DW];
            @(negedge clk);
        end
        coef_we = 1'b0;
        for (int k = 0; k < 9; k++) begin
            total++;
            if (fil_w[k] !== cv[DW*k +: DW]) begin
                bad++;
                $display("FAIL coef_load tap=%0d got=%h want=%h", k, fil_w[k], cv[DW*k +: DW]);
            end
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] p, input logic s);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        sof       = s;
        while (pix_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL pix_accept pixel=%0d got=stalled want=accepted", p);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Engine side of one window: capture taps, answer after dot_dly, drain result after rr_dly.
    task automatic service(input int dot_dly, input int rr_dly, input logic early);
        logic [DW-1:0] held [9];
        logic [RW-1:0] rd;
        logic          stable;
        int acc;
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            held[k] = tap_w[k];
            acc += int'($signed(fil_w[k])) * int'(tap_w[k]);
        end
        if (win_at.size() == 1) begin
            for (int k = 0; k < 9; k++) first_taps[k] = tap_w[k];
        end
        if (early) begin
            ready_dot  = 1'b1;
            Result_out = 20'h7FFFF;
        end
        @(negedge clk);
        ready_dot = 1'b0;
        total++;
        if ({initate, res_valid} !== 2'b00) begin
            bad++;
            $display("FAIL issue_pulse initate,res_valid got=%b want=00", {initate, res_valid});
        end
        for (int c = 0; c < dot_dly; c++) begin
            stable = 1'b1;
            for (int k = 0; k < 9; k++) if (tap_w[k] !== held[k]) stable = 1'b0;
            total++;
            if (pix_ready !== 1'b0 || res_valid !== 1'b0 || !stable) begin
                bad++;
                $display("FAIL wait_hold pix_ready=%b res_valid=%b taps_stable=%b want 0,0,1",
                         pix_ready, res_valid, stable);
            end
            @(negedge clk);
        end
        ready_dot  = 1'b1;
        Result_out = RW'(acc);
        @(negedge clk);
        ready_dot  = 1'b0;
        Result_out = '0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL res_valid_rise got=%b want=1", res_valid);
        end
        rd = res_data;
        for (int c = 0; c < rr_dly; c++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== rd || pix_ready !== 1'b0) begin
                bad++;
                $display("FAIL emit_hold res_valid=%b res_data=%h pix_ready=%b want 1,%h,0",
                         res_valid, res_data, pix_ready, rd);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        res_list.push_back(int'($signed(res_data)));
        $display("result window=%0d res_data=%0d", win_at.size(), int'($signed(res_data)));
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
            bad++;
            $display("FAIL emit_done res_valid=%b pix_ready=%b want 0,1", res_valid, pix_ready);
        end
    endtask

    task automatic drive_stream(input int n, input int sof_b, input int dot_dly,
                                input int rr_dly, input logic early);
        res_list.delete();
        win_at.delete();
        for (int i = 0; i < n; i++) begin
            send_pixel(DW'(i), (i == 0) || (i == sof_b));
            if (initate === 1'b1) begin
                win_at.push_back(i);
                service(dot_dly, rr_dly, early);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({pix_ready, initate, res_valid} !== 3'b000 || res_data !== '0) begin
            bad++;
            $display("FAIL reset_ctrl pix_ready,initate,res_valid=%b res_data=%h want 000,0",
                     {pix_ready, initate, res_valid}, res_data);
        end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (fil_w[k] !== '0 || tap_w[k] !== '0) begin
                bad++;
                $display("FAIL reset_taps idx=%0d filter=%h img=%h want 0,0", k, fil_w[k], tap_w[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (pix_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release pix_ready got=%b want=1", pix_ready);
        end
    endtask

    task automatic test_coef_load();
        logic [9*DW-1:0] cv;
        int exp_r[4] = '{5, 6, 9, 10};
        int exp_w[4] = '{10, 11, 14, 15};
        cv = '0;
        cv[4*DW +: DW] = 8'd1;
        load_coefs(cv);
        drive_stream(16, -1, 2, 0, 1'b1);
        total++;
        if (win_at.size() != 4 || res_list.size() != 4) begin
            bad++;
            $display("FAIL coef_count initate=%0d results=%0d want 4,4", win_at.size(), res_list.size());
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= res_list.size() || res_list[k] != exp_r[k] || win_at[k] != exp_w[k]) begin
                bad++;
                $display("FAIL coef_result idx=%0d want res=%0d at pixel %0d", k, exp_r[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_window_order();
        int exp_r[4] = '{45, 54, 81, 90};
        int exp_t[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        load_coefs({9{8'd1}});
        drive_stream(16, -1, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= res_list.size() || res_list[k] != exp_r[k]) begin
                bad++;
                $display("FAIL order_result idx=%0d got=%0d want=%0d", k,
                         (k < res_list.size()) ? res_list[k] : -1, exp_r[k]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (int'(first_taps[k]) != exp_t[k]) begin
                bad++;
                $display("FAIL first_window tap=%0d got=%0d want=%0d", k, first_taps[k], exp_t[k]);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int exp_r[4] = '{45, 54, 81, 90};
        drive_stream(16, -1, 7, 5, 1'b0);
        total++;
        if (res_list.size() != 4) begin
            bad++;
            $display("FAIL bp_count got=%0d want=4", res_list.size());
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= res_list.size() || res_list[k] != exp_r[k]) begin
                bad++;
                $display("FAIL bp_result idx=%0d want=%0d", k, exp_r[k]);
            end
        end
    endtask

    task automatic test_mid_sof();
        drive_stream(17, 6, 1, 1, 1'b0);
        total++;
        if (win_at.size() != 1 || win_at[0] != 16) begin
            bad++;
            $display("FAIL midsof_window count=%0d first=%0d want 1 at 16", win_at.size(),
                     (win_at.size() > 0) ? win_at[0] : -1);
        end
        total++;
        if (res_list.size() != 1 || res_list[0] != 99) begin
            bad++;
            $display("FAIL midsof_result got=%0d want=99", (res_list.size() > 0) ? res_list[0] : -1);
        end
    endtask

    task automatic test_reset_in_wait();
        for (int i = 0; i < 11; i++) send_pixel(DW'(i), i == 0);
        total++;
        if (initate !== 1'b1) begin
            bad++;
            $display("FAIL rw_initate got=%b want=1", initate);
        end
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 8'h33;
        @(negedge clk);
        coef_we = 1'b0;
        total++;
        if (filter_0 !== 8'd1 || pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL wait_coef_drop filter_0=%h pix_ready=%b want 01,0", filter_0, pix_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({res_valid, pix_ready, initate} !== 3'b010) begin
            bad++;
            $display("FAIL rw_reset res_valid,pix_ready,initate=%b want 010", {res_valid, pix_ready, initate});
        end
        ready_dot  = 1'b1;
        Result_out = 20'd123;
        @(negedge clk);
        ready_dot = 1'b0;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || res_data !== '0) begin
            bad++;
            $display("FAIL rw_stray_dot res_valid=%b res_data=%h want 0,0", res_valid, res_data);
        end
    endtask

    task automatic test_relu();
        logic [9*DW-1:0] cv;
`ifdef RELU_EN
        int exp_r[4] = '{0, 0, 0, 0};
`else
        int exp_r[4] = '{-5, -6, -9, -10};
`endif
        cv = '0;
        cv[4*DW +: DW] = 8'hFF;
        load_coefs(cv);
        drive_stream(16, -1, 1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= res_list.size() || res_list[k] != exp_r[k]) begin
                bad++;
                $display("FAIL relu_result idx=%0d got=%0d want=%0d", k,
                         (k < res_list.size()) ? res_list[k] : -999, exp_r[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coef_load();
        test_window_order();
        test_back_to_back_backpressure();
        test_mid_sof();
        test_reset_in_wait();
        test_relu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
